passcode_fsm: RTL

Door-lock code-entry controller sitting directly downstream of the keypad debounce/edge stage. Consumes its one-cycle 10-bit digit pulses plus enter/clear pulses, assembles a multi-digit code, compares it against a stored passcode, and drives unlock, error and lockout outputs. Also lets the user store a new passcode while the door is open.

---
 rtl/passcode_fsm.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/passcode_fsm.sv
// Door-lock code-entry controller.
// Collects one-hot digit pulses from the keypad front end into a BCD buffer,
// checks the buffer against the stored passcode on enter, and drives the
// unlock / alarm / err / saved outputs. While the door is open a full-length
// entry followed by enter replaces the stored passcode.
module passcode_fsm #(
    parameter int                      CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                      OPEN_CYCLES  = 50_000_000,
    parameter int                      LOCK_CYCLES  = 250_000_000,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      IDLE_TIMEOUT = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key,
    input  logic       enter,
    input  logic       clr,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic       saved,
    output logic [3:0] digit_cnt
);

    localparam int BW   = 4 * CODE_LEN;
    // OPEN and LOCKOUT never overlap, so one down-counter serves both.
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(IDLE_TIMEOUT + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [3:0]    CNT_FULL  = 4'(CODE_LEN);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // True when exactly one key line is asserted.
    function automatic logic key_is_onehot(input logic [9:0] k);
        return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
    endfunction

    // Bit position of the asserted key line (meaningful only for one-hot input).
    function automatic logic [3:0] key_index(input logic [9:0] k);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            idx = k[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    state_t          state_r, state_s;
    logic [BW-1:0]   code_r,  code_s;
    logic [BW-1:0]   buf_r,   buf_s;
    logic [3:0]      cnt_r,   cnt_s;
    logic [FW-1:0]   fail_r,  fail_s;
    logic [TW-1:0]   tmr_r,   tmr_s;
    logic [IW-1:0]   idle_r,  idle_s;
    logic            err_r,   err_s;
    logic            saved_r, saved_s;
    logic            unlock_r;
    logic            alarm_r;
    logic            key_ok_s;
    logic [3:0]      key_dig_s;

    assign key_ok_s  = key_is_onehot(key);
    assign key_dig_s = key_index(key);

    assign unlock    = unlock_r;
    assign alarm     = alarm_r;
    assign err       = err_r;
    assign saved     = saved_r;
    assign digit_cnt = cnt_r;

    // Next-state, buffer, counters and pulse outputs.
    always_comb begin
        state_s = state_r;
        code_s  = code_r;
        buf_s   = buf_r;
        cnt_s   = cnt_r;
        fail_s  = fail_r;
        tmr_s   = tmr_r;
        idle_s  = idle_r;
        err_s   = 1'b0;
        saved_s = 1'b0;

        // Digit buffer: clr/enter wipe it, a lone key shifts in, silence ages it.
        if (state_r != ST_LOCKOUT) begin
            if (clr || enter) begin
                buf_s  = {BW{1'b0}};
                cnt_s  = 4'd0;
                idle_s = {IW{1'b0}};
            end else if (key_ok_s) begin
                idle_s = {IW{1'b0}};
                if (cnt_r < CNT_FULL) begin
                    buf_s = (buf_r << 3'd4) | BW'(key_dig_s);
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    buf_s = buf_r;
                    cnt_s = cnt_r;
                end
            end else if (cnt_r != 4'd0) begin
                if (idle_r == IDLE_LAST) begin
                    buf_s  = {BW{1'b0}};
                    cnt_s  = 4'd0;
                    idle_s = {IW{1'b0}};
                end else begin
                    idle_s = idle_r + IW'(1'b1);
                end
            end else begin
                idle_s = {IW{1'b0}};
            end
        end else begin
            idle_s = {IW{1'b0}};
        end

        case (state_r)
            ST_ENTRY: begin
                // enter judges the buffer as it stood before this cycle
                if (enter && !clr) begin
                    if ((cnt_r == CNT_FULL) && (buf_r == code_r)) begin
                        state_s = ST_OPEN;
                        fail_s  = {FW{1'b0}};
                        tmr_s   = OPEN_LOAD;
                    end else begin
                        err_s  = 1'b1;
                        fail_s = fail_r + FW'(1'b1);
                        if ((fail_r + FW'(1'b1)) == FAIL_MAX) begin
                            state_s = ST_LOCKOUT;
                            tmr_s   = LOCK_LOAD;
                        end else begin
                            state_s = ST_ENTRY;
                        end
                    end
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                // A store restarts the open window, so it wins over expiry.
                if (enter && !clr && (cnt_r == CNT_FULL)) begin
                    code_s  = buf_r;
                    saved_s = 1'b1;
                    tmr_s   = OPEN_LOAD;
                end else if (tmr_r == {TW{1'b0}}) begin
                    state_s = ST_ENTRY;
                    buf_s   = {BW{1'b0}};
                    cnt_s   = 4'd0;
                    idle_s  = {IW{1'b0}};
                end else begin
                    tmr_s = tmr_r - TW'(1'b1);
                end
            end
            ST_LOCKOUT: begin
                if (tmr_r == {TW{1'b0}}) begin
                    state_s = ST_ENTRY;
                    fail_s  = {FW{1'b0}};
                    buf_s   = {BW{1'b0}};
                    cnt_s   = 4'd0;
                end else begin
                    tmr_s = tmr_r - TW'(1'b1);
                end
            end
            default: begin
                state_s = ST_ENTRY;
                buf_s   = {BW{1'b0}};
                cnt_s   = 4'd0;
                fail_s  = {FW{1'b0}};
                tmr_s   = {TW{1'b0}};
                idle_s  = {IW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs; rst restores the default code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_ENTRY;
            code_r   <= DEFAULT_CODE;
            buf_r    <= {BW{1'b0}};
            cnt_r    <= 4'd0;
            fail_r   <= {FW{1'b0}};
            tmr_r    <= {TW{1'b0}};
            idle_r   <= {IW{1'b0}};
            err_r    <= 1'b0;
            saved_r  <= 1'b0;
            unlock_r <= 1'b0;
            alarm_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            code_r   <= code_s;
            buf_r    <= buf_s;
            cnt_r    <= cnt_s;
            fail_r   <= fail_s;
            tmr_r    <= tmr_s;
            idle_r   <= idle_s;
            err_r    <= err_s;
            saved_r  <= saved_s;
            unlock_r <= (state_s == ST_OPEN);
            alarm_r  <= (state_s == ST_LOCKOUT);
        end
    end

endmodule
